// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
//   - state_t    : FSM states (value also exported on state_o for debug)
//   - iclass_t   : instruction class produced by the opcode decoder
//   - OP_*/FN_*  : opcode and R-type function field values
//   - PC_SRC_*, REG_DST_*, WB_SRC_*, ALUB_* : datapath mux encodings
//   - ALU_*      : aluop/funcop codes, unchanged from the single-cycle decoder
//   - branch_taken() : branch resolution from latched opcode and ALU flags
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_R, CL_JR, CL_JALR, CL_J, CL_JAL, CL_BR,
        CL_LOAD, CL_STORE, CL_ALUI, CL_ILL
    } iclass_t;

    localparam logic [5:0] OP_R      = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;

    localparam logic [1:0] REG_DST_RT  = 2'd0;
    localparam logic [1:0] REG_DST_RD  = 2'd1;
    localparam logic [1:0] REG_DST_R31 = 2'd2;

    localparam logic [1:0] WB_SRC_ALU = 2'd0;
    localparam logic [1:0] WB_SRC_MEM = 2'd1;
    localparam logic [1:0] WB_SRC_PC  = 2'd2;

    localparam logic [1:0] ALUB_REG  = 2'd0;
    localparam logic [1:0] ALUB_IMM  = 2'd1;
    localparam logic [1:0] ALUB_ZERO = 2'd2;

    localparam logic [3:0] ALU_AND  = 4'h0;
    localparam logic [3:0] ALU_OR   = 4'h1;
    localparam logic [3:0] ALU_ADD  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;
    localparam logic [3:0] ALU_SLL  = 4'h4;
    localparam logic [3:0] ALU_SRL  = 4'h5;
    localparam logic [3:0] ALU_SUB  = 4'h6;
    localparam logic [3:0] ALU_SLT  = 4'h7;
    localparam logic [3:0] ALU_SLTU = 4'h8;
    localparam logic [3:0] ALU_SRA  = 4'h9;
    localparam logic [3:0] ALU_LUI  = 4'hA;
    localparam logic [3:0] ALU_NOR  = 4'hC;

    // rt0 selects bgez (1) versus bltz (0) for REGIMM.
    function automatic logic branch_taken(input logic [5:0] op, input logic rt0,
                                          input logic zero, input logic neg);
        case (op)
            OP_BEQ:    return zero;
            OP_BNE:    return !zero;
            OP_BGTZ:   return !neg && !zero;
            OP_BLEZ:   return neg || zero;
            OP_REGIMM: return rt0 ? !neg : neg;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_code_dec.sv
// Combinational opcode/function decoder: classifies the latched instruction
// and supplies the ALU codes from the single-cycle decoder tables.
// Ports:
//   op, func, rt : latched instruction fields
//   cls          : instruction class (CL_ILL for unknown op / bad REGIMM rt)
//   aluop        : I-type/branch ALU code (0 for R-type)
//   funcop       : R-type ALU code
//   ext_op       : immediate is sign-extended
//   byte_acc     : byte-wide memory access (lb/lbu/sb)
module mc_alu_code_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic [4:0] rt,
    output iclass_t    cls,
    output logic [3:0] aluop,
    output logic [3:0] funcop,
    output logic       ext_op,
    output logic       byte_acc
);

    always_comb begin
        cls      = CL_ILL;
        aluop    = '0;
        funcop   = '0;
        ext_op   = 1'b0;
        byte_acc = 1'b0;
        case (op)
            OP_R: begin
                case (func)
                    FN_JR:   cls = CL_JR;
                    FN_JALR: cls = CL_JALR;
                    default: cls = CL_R;
                endcase
                case (func)
                    FN_ADD, FN_ADDU: funcop = ALU_ADD;
                    FN_SUB, FN_SUBU: funcop = ALU_SUB;
                    FN_AND:          funcop = ALU_AND;
                    FN_OR:           funcop = ALU_OR;
                    FN_XOR:          funcop = ALU_XOR;
                    FN_NOR:          funcop = ALU_NOR;
                    FN_SLT:          funcop = ALU_SLT;
                    FN_SLTU:         funcop = ALU_SLTU;
                    FN_SLL:          funcop = ALU_SLL;
                    FN_SRL:          funcop = ALU_SRL;
                    FN_SRA:          funcop = ALU_SRA;
                    default:         funcop = ALU_ADD;
                endcase
            end
            OP_J:   cls = CL_J;
            OP_JAL: cls = CL_JAL;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                cls    = CL_BR;
                aluop  = ALU_SUB;
                ext_op = 1'b1;
            end
            OP_REGIMM: begin
                if (rt == 5'd0 || rt == 5'd1) begin
                    cls    = CL_BR;
                    aluop  = ALU_SUB;
                    ext_op = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU: begin cls = CL_ALUI; aluop = ALU_ADD;  ext_op = 1'b1; end
            OP_SLTI:           begin cls = CL_ALUI; aluop = ALU_SLT;  ext_op = 1'b1; end
            OP_SLTIU:          begin cls = CL_ALUI; aluop = ALU_SLTU; ext_op = 1'b1; end
            OP_ANDI:           begin cls = CL_ALUI; aluop = ALU_AND; end
            OP_ORI:            begin cls = CL_ALUI; aluop = ALU_OR;  end
            OP_XORI:           begin cls = CL_ALUI; aluop = ALU_XOR; end
            OP_LUI:            begin cls = CL_ALUI; aluop = ALU_LUI; end
            OP_LB, OP_LBU: begin cls = CL_LOAD;  aluop = ALU_ADD; ext_op = 1'b1; byte_acc = 1'b1; end
            OP_LW:         begin cls = CL_LOAD;  aluop = ALU_ADD; ext_op = 1'b1; end
            OP_SB:         begin cls = CL_STORE; aluop = ALU_ADD; ext_op = 1'b1; byte_acc = 1'b1; end
            OP_SW:         begin cls = CL_STORE; aluop = ALU_ADD; ext_op = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port with a ready handshake, internal branch resolution, sticky
// error flags and an optional retired-instruction counter.
// Build option: define INSTRET_CNT_EN to build the instret counter;
// otherwise instret is tied to zero.
// Ports:
//   clk, rst (async, active high)
//   op/func/rt       : IR fields, captured when ir_wr fires
//   zero/neg         : ALU flags for branch resolution
//   mem_ready        : memory completes the access this cycle
//   mem_rd/mem_wr/iord/byte_en/ir_wr/pc_wr/pc_src/reg_wr/reg_dst/wb_src/
//   alusrc_b/ext_op/aluop/funcop : datapath controls
//   state_o          : current state
//   illegal/mem_tmo  : sticky error status
//   instret          : retired instruction count
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int ALUOP_W     = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic [4:0]         rt,
    input  logic               zero,
    input  logic               neg,
    input  logic               mem_ready,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               iord,
    output logic               byte_en,
    output logic               ir_wr,
    output logic               pc_wr,
    output logic [1:0]         pc_src,
    output logic               reg_wr,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wb_src,
    output logic [1:0]         alusrc_b,
    output logic               ext_op,
    output logic [ALUOP_W-1:0] aluop,
    output logic [ALUOP_W-1:0] funcop,
    output logic [2:0]         state_o,
    output logic               illegal,
    output logic               mem_tmo,
    output logic [CNT_W-1:0]   instret
);

    localparam logic [15:0] TMO_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state, state_nx;
    logic [5:0]  op_q, func_q;
    logic [4:0]  rt_q;
    logic [15:0] wait_cnt;
    logic        set_ill, set_tmo, tmo_hit;

    iclass_t     cls;
    logic [3:0]  dec_aluop, dec_funcop;
    logic        dec_ext, dec_byte;

    mc_alu_code_dec u_dec (
        .op       (op_q),
        .func     (func_q),
        .rt       (rt_q),
        .cls      (cls),
        .aluop    (dec_aluop),
        .funcop   (dec_funcop),
        .ext_op   (dec_ext),
        .byte_acc (dec_byte)
    );

    // Counter only advances while a memory access is outstanding; every
    // entry into FETCH/MEM follows a non-waiting cycle, so it starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FETCH;
            op_q     <= '0;
            func_q   <= '0;
            rt_q     <= '0;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            mem_tmo  <= 1'b0;
        end else begin
            state <= state_nx;
            if (ir_wr) begin
                op_q   <= op;
                func_q <= func;
                rt_q   <= rt;
            end
            if ((state == ST_FETCH || state == ST_MEM) && !mem_ready)
                wait_cnt <= wait_cnt + 16'd1;
            else
                wait_cnt <= '0;
            illegal <= illegal | set_ill;
            mem_tmo <= mem_tmo | set_tmo;
        end
    end

    assign state_o = state;
    assign tmo_hit = (wait_cnt == TMO_LAST) && !mem_ready;

    // Strobes are held low while rst is asserted so an in-flight memory
    // request drops immediately rather than at the next clock.
    always_comb begin
        state_nx = state;
        set_ill  = 1'b0;
        set_tmo  = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        iord     = 1'b0;
        byte_en  = 1'b0;
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        pc_src   = PC_SRC_SEQ;
        reg_wr   = 1'b0;
        reg_dst  = REG_DST_RT;
        wb_src   = WB_SRC_ALU;
        alusrc_b = ALUB_REG;
        ext_op   = 1'b0;
        aluop    = '0;
        funcop   = '0;
        if (!rst) begin
            case (state)
                ST_FETCH: begin
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        ir_wr    = 1'b1;
                        pc_wr    = 1'b1;
                        pc_src   = PC_SRC_SEQ;
                        state_nx = ST_DECODE;
                    end else if (tmo_hit) begin
                        set_tmo  = 1'b1;
                        state_nx = ST_ERR;
                    end
                end
                ST_DECODE: begin
                    case (cls)
                        CL_ILL: begin
                            set_ill  = 1'b1;
                            state_nx = ST_ERR;
                        end
                        CL_J, CL_JAL: begin
                            pc_wr    = 1'b1;
                            pc_src   = PC_SRC_JUMP;
                            state_nx = ST_FETCH;
                            if (cls == CL_JAL) begin
                                reg_wr  = 1'b1;
                                reg_dst = REG_DST_R31;
                                wb_src  = WB_SRC_PC;
                            end
                        end
                        default: state_nx = ST_EXEC;
                    endcase
                end
                ST_EXEC: begin
                    case (cls)
                        CL_R: begin
                            funcop   = ALUOP_W'(dec_funcop);
                            state_nx = ST_WB;
                        end
                        CL_JR, CL_JALR: begin
                            pc_wr    = 1'b1;
                            pc_src   = PC_SRC_RS;
                            state_nx = ST_FETCH;
                            if (cls == CL_JALR) begin
                                reg_wr  = 1'b1;
                                reg_dst = REG_DST_RD;
                                wb_src  = WB_SRC_PC;
                            end
                        end
                        CL_BR: begin
                            aluop    = ALUOP_W'(dec_aluop);
                            ext_op   = dec_ext;
                            alusrc_b = (op_q == OP_BEQ || op_q == OP_BNE) ? ALUB_REG : ALUB_ZERO;
                            pc_wr    = branch_taken(op_q, rt_q[0], zero, neg);
                            pc_src   = PC_SRC_BRANCH;
                            state_nx = ST_FETCH;
                        end
                        CL_LOAD, CL_STORE: begin
                            aluop    = ALUOP_W'(dec_aluop);
                            ext_op   = 1'b1;
                            alusrc_b = ALUB_IMM;
                            state_nx = ST_MEM;
                        end
                        CL_ALUI: begin
                            aluop    = ALUOP_W'(dec_aluop);
                            ext_op   = dec_ext;
                            alusrc_b = ALUB_IMM;
                            state_nx = ST_WB;
                        end
                        default: begin
                            set_ill  = 1'b1;
                            state_nx = ST_ERR;
                        end
                    endcase
                end
                ST_MEM: begin
                    iord    = 1'b1;
                    byte_en = dec_byte;
                    if (cls == CL_LOAD) mem_rd = 1'b1;
                    else                mem_wr = 1'b1;
                    if (mem_ready) begin
                        state_nx = (cls == CL_LOAD) ? ST_WB : ST_FETCH;
                    end else if (tmo_hit) begin
                        set_tmo  = 1'b1;
                        state_nx = ST_ERR;
                    end
                end
                ST_WB: begin
                    reg_wr   = 1'b1;
                    reg_dst  = (cls == CL_R) ? REG_DST_RD : REG_DST_RT;
                    wb_src   = (cls == CL_LOAD) ? WB_SRC_MEM : WB_SRC_ALU;
                    state_nx = ST_FETCH;
                end
                default: state_nx = ST_ERR;
            endcase
        end
    end

`ifdef INSTRET_CNT_EN
    // Every path back to FETCH from another state is a retirement; ERR
    // never returns to FETCH except through reset.
    logic             retire;
    logic [CNT_W-1:0] instret_q;

    assign retire = (state_nx == ST_FETCH) && (state != ST_FETCH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         instret_q <= '0;
        else if (retire) instret_q <= instret_q + CNT_W'(1);
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  op = '0, func = '0;
    logic [4:0]  rt = '0;
    logic        zero = 1'b0, neg = 1'b0, mem_ready = 1'b0;
    logic        mem_rd, mem_wr, iord, byte_en, ir_wr, pc_wr, reg_wr, ext_op;
    logic [1:0]  pc_src, reg_dst, wb_src, alusrc_b;
    logic [3:0]  aluop, funcop;
    logic [2:0]  state_o;
    logic        illegal, mem_tmo;
    logic [31:0] instret;

    mc_control_fsm #(.ALUOP_W(4), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .rt(rt), .zero(zero), .neg(neg),
        .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr), .iord(iord),
        .byte_en(byte_en), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_src(pc_src),
        .reg_wr(reg_wr), .reg_dst(reg_dst), .wb_src(wb_src), .alusrc_b(alusrc_b),
        .ext_op(ext_op), .aluop(aluop), .funcop(funcop), .state_o(state_o),
        .illegal(illegal), .mem_tmo(mem_tmo), .instret(instret)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, X = 3'd5;
    // strobe bits: {mem_rd, mem_wr, iord, byte_en, ir_wr, pc_wr, reg_wr, ext_op}
    localparam logic [7:0] RD = 8'h80, WR = 8'h40, IO = 8'h20, BY = 8'h10;
    localparam logic [7:0] IR = 8'h08, PW = 8'h04, RW = 8'h02, EX = 8'h01;

    typedef struct {
        string      name;
        logic [5:0] op, func;
        logic [4:0] rt;
        logic       zero, neg, rdy;
        logic [2:0] st;
        logic [7:0] strb, sel;
        logic [3:0] aop, fop;
        logic [1:0] flg;
        logic       ret;
    } vec_t;

    typedef struct {
        string       tag;
        logic [28:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   total = 0, bad = 0, exp_ret = 0;

    string      cur_name;
    logic [5:0] cur_op, cur_func;
    logic [4:0] cur_rt;
    logic       cur_zero, cur_neg;

    function automatic logic [7:0] sel(input int pc, input int rd, input int wb, input int ab);
        return {pc[1:0], rd[1:0], wb[1:0], ab[1:0]};
    endfunction

    function automatic logic [28:0] actual();
        return {state_o, mem_rd, mem_wr, iord, byte_en, ir_wr, pc_wr, reg_wr, ext_op,
                pc_src, reg_dst, wb_src, alusrc_b, aluop, funcop, illegal, mem_tmo};
    endfunction

    task automatic ins(input string n, input int o, input int f, input int r, input int z, input int ng);
        cur_name = n; cur_op = 6'(o); cur_func = 6'(f); cur_rt = 5'(r);
        cur_zero = z[0]; cur_neg = ng[0];
    endtask

    function automatic vec_t mk(input int rdy, input logic [2:0] st, input logic [7:0] strb,
                                input logic [7:0] sl, input int aop, input int fop,
                                input int flg, input int ret);
        vec_t t;
        t.name = cur_name; t.op = cur_op; t.func = cur_func; t.rt = cur_rt;
        t.zero = cur_zero; t.neg = cur_neg; t.rdy = rdy[0];
        t.st = st; t.strb = strb; t.sel = sl; t.aop = 4'(aop); t.fop = 4'(fop);
        t.flg = 2'(flg); t.ret = ret[0];
        return t;
    endfunction

    task automatic c(input int rdy, input logic [2:0] st, input logic [7:0] strb,
                     input logic [7:0] sl, input int aop, input int fop, input int ret);
        tbl.push_back(mk(rdy, st, strb, sl, aop, fop, 0, ret));
    endtask

    task automatic check_out();
        sb_t e;
        logic [28:0] a;
        e = sbq.pop_front();
        a = actual();
        total++;
        if (a !== e.exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", e.tag, a, e.exp);
        end
    endtask

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, got, want);
        end
    endtask

    // Called at a falling edge; returns at the falling edge one cycle later.
    task automatic apply(input vec_t t, input string tag);
        sb_t e;
        op = t.op; func = t.func; rt = t.rt;
        zero = t.zero; neg = t.neg; mem_ready = t.rdy;
        e.tag = tag;
        e.exp = {t.st, t.strb, t.sel, t.aop, t.fop, t.flg};
        sbq.push_back(e);
        #2;
        check_out();
        @(negedge clk);
        if (t.ret) exp_ret++;
    endtask

    task automatic hc(input int rdy, input logic [2:0] st, input logic [7:0] strb,
                      input logic [7:0] sl, input int flg, input string tag);
        apply(mk(rdy, st, strb, sl, 0, 0, flg, 0), tag);
    endtask

    function automatic logic [31:0] want_ret();
`ifdef INSTRET_CNT_EN
        return 32'(exp_ret);
`else
        return 32'd0;
`endif
    endfunction

    task automatic do_reset(input string tag);
        sb_t e;
        rst = 1'b1;
        mem_ready = 1'b0;
        #2;
        e.tag = tag;
        e.exp = '0;
        sbq.push_back(e);
        check_out();
        chk({tag, "_instret"}, instret, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        do_reset("reset");

        ins("add", 6'h00, 6'h20, 0, 0, 0);
        c(1, F, RD|IR|PW, 8'h00, 0, 0, 0);
        c(1, D, 8'h00, 8'h00, 0, 0, 0);
        c(1, E, 8'h00, 8'h00, 0, 2, 0);
        c(1, W, RW, sel(0,1,0,0), 0, 0, 1);

        ins("lw", 6'h23, 0, 0, 0, 0);
        c(1, F, RD|IR|PW, 8'h00, 0, 0, 0);
        c(1, D, 8'h00, 8'h00, 0, 0, 0);
        c(1, E, EX, sel(0,0,0,1), 2, 0, 0);
        c(0, M, RD|IO, 8'h00, 0, 0, 0);
        c(0, M, RD|IO, 8'h00, 0, 0, 0);
        c(0, M, RD|IO, 8'h00, 0, 0, 0);
        c(1, M, RD|IO, 8'h00, 0, 0, 0);
        c(1, W, RW, sel(0,0,1,0), 0, 0, 1);

        ins("beq_taken", 6'h04, 0, 0, 1, 0);
        c(1, F, RD|IR|PW, 8'h00, 0, 0, 0);
        c(1, D, 8'h00, 8'h00, 0, 0, 0);
        c(1, E, PW|EX, sel(1,0,0,0), 6, 0, 1);

        ins("beq_not", 6'h04, 0, 0, 0, 0);
        c(1, F, RD|IR|PW, 8'h00, 0, 0, 0);
        c(1, D, 8'h00, 8'h00, 0, 0, 0);
        c(1, E, EX, sel(1,0,0,0), 6, 0, 1);

        ins("bgtz", 6'h07, 0, 0, 0, 0);
        c(1, F, RD|IR|PW, 8'h00, 0, 0, 0);
        c(1, D, 8'h00, 8'h00, 0, 0, 0);
        c(1, E, PW|EX, sel(1,0,0,2), 6, 0, 1);

        ins("bltz", 6'h01, 0, 0, 0, 1);
        c(1, F, RD|IR|PW, 8'h00, 0, 0, 0);
        c(1, D, 8'h00, 8'h00, 0, 0, 0);
        c(1, E, PW|EX, sel(1,0,0,2), 6, 0, 1);

        ins("bgez_not", 6'h01, 0, 1, 0, 1);
        c(1, F, RD|IR|PW, 8'h00, 0, 0, 0);
        c(1, D, 8'h00, 8'h00, 0, 0, 0);
        c(1, E, EX, sel(1,0,0,2), 6, 0, 1);

        ins("jal", 6'h03, 0, 0, 0, 0);
        c(1, F, RD|IR|PW, 8'h00, 0, 0, 0);
        c(1, D, PW|RW, sel(2,2,2,0), 0, 0, 1);

        ins("sb", 6'h28, 0, 0, 0, 0);
        c(1, F, RD|IR|PW, 8'h00, 0, 0, 0);
        c(1, D, 8'h00, 8'h00, 0, 0, 0);
        c(1, E, EX, sel(0,0,0,1), 2, 0, 0);
        c(1, M, WR|IO|BY, 8'h00, 0, 0, 1);

        ins("ori", 6'h0D, 0, 0, 0, 0);
        c(1, F, RD|IR|PW, 8'h00, 0, 0, 0);
        c(1, D, 8'h00, 8'h00, 0, 0, 0);
        c(1, E, 8'h00, sel(0,0,0,1), 1, 0, 0);
        c(1, W, RW, 8'h00, 0, 0, 1);

        ins("jr", 6'h00, 6'h08, 0, 0, 0);
        c(1, F, RD|IR|PW, 8'h00, 0, 0, 0);
        c(1, D, 8'h00, 8'h00, 0, 0, 0);
        c(1, E, PW, sel(3,0,0,0), 0, 0, 1);

        ins("jalr", 6'h00, 6'h09, 0, 0, 0);
        c(1, F, RD|IR|PW, 8'h00, 0, 0, 0);
        c(1, D, 8'h00, 8'h00, 0, 0, 0);
        c(1, E, PW|RW, sel(3,1,2,0), 0, 0, 1);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("%s[%0d]", tbl[i].name, i));
        chk("instret_after_table", instret, want_ret());

        ins("illegal_op", 6'h3F, 0, 0, 0, 0);
        hc(1, F, RD|IR|PW, 8'h00, 0, "illegal_op_fetch");
        hc(1, D, 8'h00, 8'h00, 0, "illegal_op_decode");
        hc(1, X, 8'h00, 8'h00, 2, "illegal_op_err");
        hc(1, X, 8'h00, 8'h00, 2, "illegal_op_err_hold");
        do_reset("reset_after_illegal");

        ins("regimm_rt2", 6'h01, 0, 2, 0, 0);
        hc(1, F, RD|IR|PW, 8'h00, 0, "regimm_rt2_fetch");
        hc(1, D, 8'h00, 8'h00, 0, "regimm_rt2_decode");
        hc(1, X, 8'h00, 8'h00, 2, "regimm_rt2_err");
        do_reset("reset_after_regimm");

        ins("tmo", 6'h00, 6'h20, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            hc(0, F, RD, 8'h00, 0, $sformatf("tmo_wait%0d", i));
        hc(0, X, 8'h00, 8'h00, 1, "tmo_err");
        hc(1, X, 8'h00, 8'h00, 1, "tmo_err_hold");
        hc(1, X, 8'h00, 8'h00, 1, "tmo_err_hold2");
        do_reset("reset_after_tmo");

        hc(0, F, RD, 8'h00, 0, "mid_fetch_before");
        do_reset("reset_mid_fetch");
        hc(0, F, RD, 8'h00, 0, "mid_fetch_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
